// File: rtl/ariane_timer_sched_if.sv
// APB master/slave bundle between ariane_timer_sched and the platform timer.
// Carries the compare-register write channel (PADDR/PWDATA/PWRITE/PSEL/PENABLE)
// and the slave response (PREADY/PSLVERR).
interface ariane_timer_sched_if #(
   parameter int unsigned APB_ADDR_WIDTH = 12
);
   logic [APB_ADDR_WIDTH-1:0] PADDR;
   logic [63:0]               PWDATA;
   logic                      PWRITE;
   logic                      PSEL;
   logic                      PENABLE;
   logic                      PREADY;
   logic                      PSLVERR;

   modport master (
      output PADDR,
      output PWDATA,
      output PWRITE,
      output PSEL,
      output PENABLE,
      input  PREADY,
      input  PSLVERR
   );

   modport slave (
      input  PADDR,
      input  PWDATA,
      input  PWRITE,
      input  PSEL,
      input  PENABLE,
      output PREADY,
      output PSLVERR
   );
endinterface

// File: rtl/ariane_timer_sched.sv
// ariane_timer_sched: multiplexes NR_SLOTS one-shot deadlines onto the single
// mtimecmp register of the platform timer. Each armed slot is flagged in
// expired_o once mtime reaches its deadline; the earliest pending deadline (or
// all-ones when nothing is pending) is kept programmed in the timer through an
// APB master port.
// Optional feature macro: TIMER_SCHED_ERR_EN adds err_o/err_clr_i, makes
// PSLVERR sticky-flag an error and forces a retry of the failed write.
module ariane_timer_sched #(
   parameter int unsigned               NR_SLOTS       = 4,
   parameter int unsigned               APB_ADDR_WIDTH = 12,
   parameter logic [APB_ADDR_WIDTH-1:0] CMP_BASE       = 12'h400,
   parameter int unsigned               HART_ID        = 0,
   localparam int unsigned              SLOT_W         = (NR_SLOTS > 1) ? $clog2(NR_SLOTS) : 1
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   input  logic [63:0]         time_i,
   input  logic                arm_valid_i,
   input  logic [SLOT_W-1:0]   arm_slot_i,
   input  logic [63:0]         arm_deadline_i,
   input  logic [NR_SLOTS-1:0] cancel_i,
   output logic [NR_SLOTS-1:0] expired_o,
   input  logic [NR_SLOTS-1:0] expired_ack_i,
`ifdef TIMER_SCHED_ERR_EN
   output logic                err_o,
   input  logic                err_clr_i,
`endif
   ariane_timer_sched_if.master apb
);

   if (NR_SLOTS < 1 || NR_SLOTS > 16) begin : g_bad_nr_slots
      $error("ariane_timer_sched: NR_SLOTS must be within 1..16");
   end

   localparam logic [APB_ADDR_WIDTH-1:0] WR_ADDR =
      CMP_BASE + APB_ADDR_WIDTH'(HART_ID * 8);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;

   logic [NR_SLOTS-1:0] valid_q;
   logic [63:0]         deadline_q [NR_SLOTS];
   logic [NR_SLOTS-1:0] expired_q;
   logic [NR_SLOTS-1:0] arm_hit;
   logic [NR_SLOTS-1:0] due;
   logic [63:0]         next_cmp;

   logic [1:0]          state_q;
   logic [63:0]         wdata_q;
   logic [63:0]         programmed_q;
   logic                busy;
   logic                write_ok;

   // Decode the arm request per slot and find slots whose deadline has passed.
   always_comb begin
      arm_hit = '0;
      due     = '0;
      for (int unsigned i = 0; i < NR_SLOTS; i++) begin
         arm_hit[i] = arm_valid_i && (arm_slot_i == SLOT_W'(i));
         due[i]     = valid_q[i] && (time_i >= deadline_q[i]);
      end
   end

   // Slot state: arm beats expiry and cancel; expiry set beats acknowledge.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         valid_q   <= '0;
         expired_q <= '0;
         for (int unsigned i = 0; i < NR_SLOTS; i++) begin
            deadline_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NR_SLOTS; i++) begin
            if (arm_hit[i]) begin
               valid_q[i]    <= 1'b1;
               deadline_q[i] <= arm_deadline_i;
               expired_q[i]  <= 1'b0;
            end else if (due[i]) begin
               valid_q[i]   <= 1'b0;
               expired_q[i] <= 1'b1;
            end else begin
               if (cancel_i[i]) begin
                  valid_q[i] <= 1'b0;
               end
               if (expired_ack_i[i]) begin
                  expired_q[i] <= 1'b0;
               end
            end
         end
      end
   end

   // Earliest pending deadline; strict compare keeps the lowest index on ties.
   always_comb begin
      next_cmp = '1;
      for (int unsigned i = 0; i < NR_SLOTS; i++) begin
         if (valid_q[i] && (deadline_q[i] < next_cmp)) begin
            next_cmp = deadline_q[i];
         end
      end
   end

`ifdef TIMER_SCHED_ERR_EN
   assign write_ok = ~apb.PSLVERR;

   // Sticky error flag; a same-cycle error wins over the clear.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         err_o <= 1'b0;
      end else if ((state_q == ACCESS) && apb.PREADY && apb.PSLVERR) begin
         err_o <= 1'b1;
      end else if (err_clr_i) begin
         err_o <= 1'b0;
      end
   end
`else
   assign write_ok = 1'b1;
`endif

   // APB write sequencer: launches a write whenever the target differs from
   // the value last committed to the timer; an in-flight write always finishes.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q      <= IDLE;
         wdata_q      <= '0;
         programmed_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (next_cmp != programmed_q) begin
                  wdata_q <= next_cmp;
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               state_q <= ACCESS;
            end
            ACCESS: begin
               if (apb.PREADY) begin
                  state_q <= IDLE;
                  if (write_ok) begin
                     programmed_q <= wdata_q;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy        = (state_q != IDLE);
   assign apb.PSEL    = busy;
   assign apb.PENABLE = (state_q == ACCESS);
   assign apb.PWRITE  = busy;
   assign apb.PADDR   = busy ? WR_ADDR : '0;
   assign apb.PWDATA  = busy ? wdata_q : '0;
   assign expired_o   = expired_q;

endmodule

// File: tb/tb_ariane_timer_sched.sv
// Bench for ariane_timer_sched: a transaction-level reference of the slots and
// the compare-register write stream, checked against the DUT every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_ariane_timer_sched;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [63:0] time_i;
   logic        arm_valid_i;
   logic [1:0]  arm_slot_i;
   logic [63:0] arm_deadline_i;
   logic [3:0]  cancel_i;
   logic [3:0]  expired_o;
   logic [3:0]  expired_ack_i;
`ifdef TIMER_SCHED_ERR_EN
   logic        err_o;
   logic        err_clr_i;
`endif

   int checks = 0;
   int errors = 0;

   ariane_timer_sched_if #(.APB_ADDR_WIDTH(12)) apb ();

   ariane_timer_sched #(
      .NR_SLOTS       (4),
      .APB_ADDR_WIDTH (12),
      .CMP_BASE       (12'h400),
      .HART_ID        (0)
   ) dut (
      .HCLK           (HCLK),
      .HRESETn        (HRESETn),
      .time_i         (time_i),
      .arm_valid_i    (arm_valid_i),
      .arm_slot_i     (arm_slot_i),
      .arm_deadline_i (arm_deadline_i),
      .cancel_i       (cancel_i),
      .expired_o      (expired_o),
      .expired_ack_i  (expired_ack_i),
`ifdef TIMER_SCHED_ERR_EN
      .err_o          (err_o),
      .err_clr_i      (err_clr_i),
`endif
      .apb            (apb)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit          m_valid [4];
   logic [63:0] m_dl    [4];
   bit          m_exp   [4];
   int          m_phase;          // 0: no transfer, 1: setup beat, 2: access beat
   logic [63:0] m_wdata;
   logic [63:0] m_prog;
   bit          m_err;
   logic [63:0] m_tgt;
   logic [63:0] wr_log [$];        // values of completed writes seen on the bus

   // Earliest pending deadline, all-ones when nothing is pending.
   function automatic logic [63:0] model_target();
      longint unsigned pend [$];
      longint unsigned lo [$];
      for (int i = 0; i < 4; i++)
         if (m_valid[i]) pend.push_back(m_dl[i]);
      if (pend.size() == 0) return ONES;
      lo = pend.min();
      return lo[0];
   endfunction

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0; m_dl[i] = '0; m_exp[i] = 0;
         end
         m_phase = 0; m_wdata = '0; m_prog = '0; m_err = 0;
      end else begin
         m_tgt = model_target();
         for (int i = 0; i < 4; i++) begin
            if (arm_valid_i && int'(arm_slot_i) == i) begin
               m_valid[i] = 1; m_dl[i] = arm_deadline_i; m_exp[i] = 0;
            end else if (m_valid[i] && time_i >= m_dl[i]) begin
               m_valid[i] = 0; m_exp[i] = 1;
            end else begin
               if (cancel_i[i]) m_valid[i] = 0;
               if (expired_ack_i[i]) m_exp[i] = 0;
            end
         end
`ifdef TIMER_SCHED_ERR_EN
         if (m_phase == 2 && apb.PREADY && apb.PSLVERR) m_err = 1;
         else if (err_clr_i) m_err = 0;
`endif
         if (m_phase == 0) begin
            if (m_tgt != m_prog) begin
               m_wdata = m_tgt; m_phase = 1;
            end
         end else if (m_phase == 1) begin
            m_phase = 2;
         end else if (apb.PREADY) begin
            m_phase = 0;
`ifdef TIMER_SCHED_ERR_EN
            if (!apb.PSLVERR) m_prog = m_wdata;
`else
            m_prog = m_wdata;
`endif
         end
      end
   end

   // Per-cycle comparison of all DUT outputs against the model.
   always @(negedge HCLK) begin
      logic [3:0] e;
      for (int i = 0; i < 4; i++) e[i] = m_exp[i];
      chk("expired_o", 64'(expired_o), 64'(e));
      chk("PSEL", 64'(apb.PSEL), 64'(m_phase != 0));
      chk("PENABLE", 64'(apb.PENABLE), 64'(m_phase == 2));
      chk("PWRITE", 64'(apb.PWRITE), 64'(m_phase != 0));
      chk("PADDR", 64'(apb.PADDR), (m_phase != 0) ? 64'h400 : 64'h0);
      chk("PWDATA", apb.PWDATA, (m_phase != 0) ? m_wdata : 64'h0);
`ifdef TIMER_SCHED_ERR_EN
      chk("err_o", 64'(err_o), 64'(m_err));
`endif
      if (apb.PSEL && apb.PENABLE && apb.PREADY) wr_log.push_back(apb.PWDATA);
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic arm(input int slot, input logic [63:0] dl);
      arm_valid_i    = 1'b1;
      arm_slot_i     = 2'(slot);
      arm_deadline_i = dl;
      tick();
      arm_valid_i    = 1'b0;
   endtask

   task automatic ack(input logic [3:0] bits);
      expired_ack_i = bits;
      tick();
      expired_ack_i = '0;
   endtask

   task automatic chk_log(input string name, input int idx, input logic [63:0] exp);
      if (idx >= wr_log.size()) begin
         checks++;
         errors++;
         $display("FAIL %s actual=missing(write count %0d) required=%h", name, wr_log.size(), exp);
      end else begin
         chk(name, wr_log[idx], exp);
      end
   endtask

   int mark;

   initial begin
      HRESETn        = 1'b0;
      time_i         = '0;
      arm_valid_i    = 1'b0;
      arm_slot_i     = '0;
      arm_deadline_i = '0;
      cancel_i       = '0;
      expired_ack_i  = '0;
      apb.PREADY     = 1'b1;
      apb.PSLVERR    = 1'b0;
`ifdef TIMER_SCHED_ERR_EN
      err_clr_i      = 1'b0;
`endif
      repeat (3) @(posedge HCLK);
      #1;
      chk("reset_psel", 64'(apb.PSEL), 64'h0);
      chk("reset_pwdata", apb.PWDATA, 64'h0);
      chk("reset_expired", 64'(expired_o), 64'h0);
      HRESETn = 1'b1;

      // 1: first write after reset silences the timer with all-ones
      tick();
      chk("t1_psel_c1", 64'(apb.PSEL), 64'h1);
      chk("t1_penable_c1", 64'(apb.PENABLE), 64'h0);
      chk("t1_paddr", 64'(apb.PADDR), 64'h400);
      chk("t1_pwdata", apb.PWDATA, ONES);
      tick();
      chk("t1_penable_c2", 64'(apb.PENABLE), 64'h1);
      tick();
      chk("t1_idle", 64'(apb.PSEL), 64'h0);
      wait_cycles(4);
      chk("t1_nwrites", 64'(wr_log.size()), 64'd1);
      chk_log("t1_w0", 0, ONES);

      // 2: two arms, earliest written last; expiry of slot1 reverts to 100
      mark = wr_log.size();
      arm(0, 64'd100);
      arm(1, 64'd50);
      wait_cycles(10);
      chk_log("t2_w0", mark, 64'd100);
      chk_log("t2_w1", mark + 1, 64'd50);
      time_i = 64'd50;
      tick();
      chk("t2_expired", 64'(expired_o), 64'b0010);
      wait_cycles(6);
      ack(4'b0010);
      wait_cycles(2);
      chk_log("t2_w2", mark + 2, 64'd100);
      chk("t2_acked", 64'(expired_o), 64'h0);

      // 3: stalled transfer with a re-arm in flight
      time_i     = 64'd10;
      apb.PREADY = 1'b0;
      mark = wr_log.size();
      arm(3, 64'd70);
      wait_cycles(2);
      arm(3, 64'd30);
      wait_cycles(3);
      chk("t3_stall_penable", 64'(apb.PENABLE), 64'h1);
      chk("t3_stall_pwdata", apb.PWDATA, 64'd70);
      apb.PREADY = 1'b1;
      wait_cycles(8);
      chk_log("t3_w0", mark, 64'd70);
      chk_log("t3_w1", mark + 1, 64'd30);
      time_i = 64'd100;
      tick();
      chk("t3_expired", 64'(expired_o), 64'b1001);
      ack(4'b1001);
      wait_cycles(8);
      chk_log("t3_w2", mark + 2, ONES);

      // 4: deadline already passed; then expiry colliding with its ack
      time_i = 64'd20;
      mark = wr_log.size();
      arm(2, 64'd10);
      tick();
      chk("t4_expired", 64'(expired_o), 64'b0100);
      wait_cycles(8);
      chk_log("t4_w0", mark, 64'd10);
      chk_log("t4_w1", mark + 1, ONES);
      ack(4'b0100);
      chk("t4_acked", 64'(expired_o), 64'h0);
      arm(1, 64'd25);
      time_i        = 64'd30;
      expired_ack_i = 4'b0010;
      tick();
      expired_ack_i = '0;
      chk("t4_set_beats_ack", 64'(expired_o), 64'b0010);
      wait_cycles(8);
      ack(4'b0010);

      // 5: arm + cancel + expiry on slot0 in one cycle
      arm(0, 64'd5);
      arm_valid_i    = 1'b1;
      arm_slot_i     = 2'd0;
      arm_deadline_i = 64'd200;
      cancel_i       = 4'b0001;
      tick();
      arm_valid_i = 1'b0;
      cancel_i    = '0;
      chk("t5_no_expiry", 64'(expired_o), 64'h0);
      wait_cycles(10);
      time_i = 64'd200;
      tick();
      chk("t5_expires_200", 64'(expired_o), 64'b0001);
      ack(4'b0001);
      wait_cycles(8);

      // 6: slave error on the compare write
      mark = wr_log.size();
      apb.PSLVERR = 1'b1;
`ifdef TIMER_SCHED_ERR_EN
      arm(2, 64'd300);
      wait_cycles(3);
      chk("t6_err_set", 64'(err_o), 64'h1);
      apb.PSLVERR = 1'b0;
      wait_cycles(8);
      chk_log("t6_w0", mark, 64'd300);
      chk_log("t6_retry", mark + 1, 64'd300);
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      chk("t6_err_clr", 64'(err_o), 64'h0);
`else
      arm(2, 64'd300);
      wait_cycles(8);
      apb.PSLVERR = 1'b0;
      chk_log("t6_w0", mark, 64'd300);
      chk("t6_no_retry", 64'(wr_log.size()), 64'(mark + 1));
`endif

      // cancel of the last pending slot returns the target to all-ones
      mark = wr_log.size();
      cancel_i = 4'b0100;
      tick();
      cancel_i = '0;
      wait_cycles(8);
      chk_log("cancel_w0", mark, ONES);
      chk("cancel_expired", 64'(expired_o), 64'h0);

      // reset in the middle of a transfer drops the bus at once
      arm(1, 64'd900);
      tick();
      HRESETn = 1'b0;
      #1;
      chk("rst_mid_psel", 64'(apb.PSEL), 64'h0);
      tick();
      HRESETn = 1'b1;
      mark = wr_log.size();
      wait_cycles(6);
      chk_log("rst_rewrite", mark, ONES);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
